// File: rtl/systolic_seq_pkg.sv
// Shared states, array opcodes and helpers for the systolic layer sequencer.
// Imported by seq_phase_counter and systolic_layer_sequencer.
package systolic_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        LOADW  = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        INTRA  = 3'd5,
        DONE   = 3'd6
    } seq_state_t;

    localparam logic [2:0] OP_IDLE    = 3'd0;
    localparam logic [2:0] OP_LOADW   = 3'd1;
    localparam logic [2:0] OP_COMPUTE = 3'd2;
    localparam logic [2:0] OP_DRAIN   = 3'd3;

    // Opcode the array sees while the sequencer sits in a given state
    function automatic logic [2:0] state_opcode(input seq_state_t s);
        case (s)
            LOADW:   return OP_LOADW;
            STREAM:  return OP_COMPUTE;
            DRAIN:   return OP_DRAIN;
            default: return OP_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/systolic_layer_sequencer_counter.sv
// seq_phase_counter: loadable down-counter with a terminal (count==1) flag.
// Holds at zero once exhausted; the owning FSM reloads it on every state entry.
import systolic_seq_pkg::*;

module seq_phase_counter #(
    parameter int W = 6
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_term
);

    logic [W-1:0] r_count;

    // Load on phase entry, otherwise count down and stick at zero
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_term = (r_count == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/systolic_layer_sequencer.sv
// Per-tile controller: clear, weight preload, activation stream, drain, optional O->A copy.
// Optional Intra_net watchdog enabled by defining SEQ_INTRA_TIMEOUT_EN.
import systolic_seq_pkg::*;

module systolic_layer_sequencer #(
    parameter int ARRAY_N    = 16,
    parameter int ARRAY_M    = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int DRAIN_LAT  = ARRAY_N + ARRAY_M,
    parameter int TIMEOUT    = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic [$clog2(ARRAY_N):0]      i_cfg_num_rows,
    input  logic [$clog2(ARRAY_M):0]      i_cfg_num_cols,
    input  logic [ADDR_WIDTH-1:0]         i_cfg_a_base,
    input  logic [ADDR_WIDTH-1:0]         i_cfg_w_base,
    input  logic [ADDR_WIDTH-1:0]         i_cfg_o_base,
    input  logic                          i_cfg_chain,
    input  logic [ADDR_WIDTH-1:0]         i_cfg_intra_o_base,
    input  logic [ADDR_WIDTH-1:0]         i_cfg_intra_a_base,
    input  logic                          i_Intra_sig_end,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_err,
    output logic                          o_sa_reset,
    output logic                          o_a_buf_on,
    output logic                          o_w_buf_on,
    output logic                          o_mode,
    output logic                          o_o_ag_o_on,
    output logic                          o_Intranet_on,
    output logic                          o_Intra_sig_start,
    output logic [2:0]                    o_operation_signal_in,
    output logic [ADDR_WIDTH-1:0]         o_a_base_addr,
    output logic [ADDR_WIDTH-1:0]         o_w_base_addr,
    output logic [ADDR_WIDTH-1:0]         o_o_base_addr,
    output logic [ADDR_WIDTH-1:0]         o_Intra_O_base_addr,
    output logic [ADDR_WIDTH-1:0]         o_Intra_A_base_addr,
    output logic [$clog2(ARRAY_N):0]      o_a_num_rows,
    output logic [$clog2(ARRAY_M):0]      o_w_num_cols
);

    localparam int ROW_W = $clog2(ARRAY_N) + 1;
    localparam int COL_W = $clog2(ARRAY_M) + 1;
    localparam int CNT_W = $clog2(DRAIN_LAT) + 1;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    seq_state_t              r_state;
    seq_state_t              w_next;
    logic                    w_accept;
    logic                    w_zero_dim;
    logic                    w_cnt_load;
    logic [CNT_W-1:0]        w_cnt_val;
    logic                    w_term;

    logic                    r_busy;
    logic                    r_done;
    logic                    r_sa_reset;
    logic                    r_a_buf_on;
    logic                    r_w_buf_on;
    logic                    r_mode;
    logic                    r_o_ag_o_on;
    logic                    r_intranet_on;
    logic                    r_intra_start;
    logic [2:0]              r_op;
    logic [ADDR_WIDTH-1:0]   r_a_base;
    logic [ADDR_WIDTH-1:0]   r_w_base;
    logic [ADDR_WIDTH-1:0]   r_o_base;
    logic [ADDR_WIDTH-1:0]   r_intra_o_base;
    logic [ADDR_WIDTH-1:0]   r_intra_a_base;
    logic [ROW_W-1:0]        r_rows;
    logic [COL_W-1:0]        r_cols;
    logic                    r_chain;

    assign w_accept   = (r_state == IDLE) && i_start;
    assign w_zero_dim = (i_cfg_num_rows == '0) || (i_cfg_num_cols == '0);

`ifdef SEQ_INTRA_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            w_timeout;
    logic            r_err;

    assign w_timeout = (r_state == INTRA) && !i_Intra_sig_end
                     && (r_wd_cnt == WD_W'(TIMEOUT));

    // Count INTRA cycles; 1 on the first INTRA cycle
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wd_cnt <= '0;
        end else if (w_next == INTRA) begin
            r_wd_cnt <= (r_state == INTRA) ? r_wd_cnt + 1'b1 : WD_W'(1);
        end else begin
            r_wd_cnt <= '0;
        end
    end

    // Sticky watchdog flag; a zero-size tile leaves it alone
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_err <= 1'b0;
        end else if (w_accept && !w_zero_dim) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    // Next-state decode; phase lengths come from the shared counter
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next = w_zero_dim ? DONE : CLR;
                end
            end
            CLR: begin
                if (w_term) w_next = LOADW;
            end
            LOADW: begin
                if (w_term) w_next = STREAM;
            end
            STREAM: begin
                if (w_term) w_next = DRAIN;
            end
            DRAIN: begin
                if (w_term) w_next = r_chain ? INTRA : DONE;
            end
            INTRA: begin
                if (i_Intra_sig_end) w_next = DONE;
`ifdef SEQ_INTRA_TIMEOUT_EN
                if (w_timeout) w_next = DONE;
`endif
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Reload the phase counter with the length of the state being entered
    always_comb begin
        w_cnt_load = (w_next != r_state);
        w_cnt_val  = '0;
        unique case (w_next)
            CLR:     w_cnt_val = CNT_W'(1);
            LOADW:   w_cnt_val = CNT_W'(r_cols);
            STREAM:  w_cnt_val = CNT_W'(r_rows);
            DRAIN:   w_cnt_val = CNT_W'(DRAIN_LAT);
            default: w_cnt_val = '0;
        endcase
    end

    seq_phase_counter #(
        .W (CNT_W)
    ) u_phase_cnt (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .o_term     (w_term)
    );

    // State register plus outputs registered from the next state
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_sa_reset     <= 1'b0;
            r_a_buf_on     <= 1'b0;
            r_w_buf_on     <= 1'b0;
            r_mode         <= 1'b0;
            r_o_ag_o_on    <= 1'b0;
            r_intranet_on  <= 1'b0;
            r_intra_start  <= 1'b0;
            r_op           <= OP_IDLE;
            r_a_base       <= '0;
            r_w_base       <= '0;
            r_o_base       <= '0;
            r_intra_o_base <= '0;
            r_intra_a_base <= '0;
            r_rows         <= '0;
            r_cols         <= '0;
            r_chain        <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_busy        <= (w_next != IDLE) && (w_next != DONE);
            r_done        <= (w_next == DONE);
            r_sa_reset    <= (w_next == CLR);
            r_w_buf_on    <= (w_next == LOADW);
            r_mode        <= (w_next == LOADW);
            r_a_buf_on    <= (w_next == STREAM);
            r_o_ag_o_on   <= (w_next == DRAIN);
            r_intranet_on <= (w_next == INTRA);
            r_intra_start <= (w_next == INTRA) && (r_state != INTRA);
            r_op          <= state_opcode(w_next);
            if (w_accept) begin
                r_a_base       <= i_cfg_a_base;
                r_w_base       <= i_cfg_w_base;
                r_o_base       <= i_cfg_o_base;
                r_intra_o_base <= i_cfg_intra_o_base;
                r_intra_a_base <= i_cfg_intra_a_base;
                r_rows         <= i_cfg_num_rows;
                r_cols         <= i_cfg_num_cols;
                r_chain        <= i_cfg_chain;
            end
        end
    end

    assign o_busy                = r_busy;
    assign o_done                = r_done;
    assign o_sa_reset            = r_sa_reset;
    assign o_a_buf_on            = r_a_buf_on;
    assign o_w_buf_on            = r_w_buf_on;
    assign o_mode                = r_mode;
    assign o_o_ag_o_on           = r_o_ag_o_on;
    assign o_Intranet_on         = r_intranet_on;
    assign o_Intra_sig_start     = r_intra_start;
    assign o_operation_signal_in = r_op;
    assign o_a_base_addr         = r_a_base;
    assign o_w_base_addr         = r_w_base;
    assign o_o_base_addr         = r_o_base;
    assign o_Intra_O_base_addr   = r_intra_o_base;
    assign o_Intra_A_base_addr   = r_intra_a_base;
    assign o_a_num_rows          = r_rows;
    assign o_w_num_cols          = r_cols;

endmodule

// File: tb/tb_systolic_layer_sequencer.sv
// Bench for systolic_layer_sequencer: tile table with a scoreboard, plus abort/reset sequences.
// Timeout vectors run only when SEQ_INTRA_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_systolic_layer_sequencer;
    import systolic_seq_pkg::*;

    localparam int N      = 16;
    localparam int M      = 16;
    localparam int AW     = 10;
    localparam int DL     = N + M;
    localparam int TO     = 20;
    localparam int RW     = $clog2(N) + 1;
    localparam int CW     = $clog2(M) + 1;
    localparam int BUDGET = 200;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_start;
    logic [RW-1:0] i_cfg_num_rows;
    logic [CW-1:0] i_cfg_num_cols;
    logic [AW-1:0] i_cfg_a_base, i_cfg_w_base, i_cfg_o_base;
    logic          i_cfg_chain;
    logic [AW-1:0] i_cfg_intra_o_base, i_cfg_intra_a_base;
    logic          i_Intra_sig_end;
    logic          o_busy, o_done, o_err, o_sa_reset, o_a_buf_on, o_w_buf_on, o_mode;
    logic          o_o_ag_o_on, o_Intranet_on, o_Intra_sig_start;
    logic [2:0]    o_operation_signal_in;
    logic [AW-1:0] o_a_base_addr, o_w_base_addr, o_o_base_addr;
    logic [AW-1:0] o_Intra_O_base_addr, o_Intra_A_base_addr;
    logic [RW-1:0] o_a_num_rows;
    logic [CW-1:0] o_w_num_cols;

    always #5 clk = ~clk;

    systolic_layer_sequencer #(
        .ARRAY_N(N), .ARRAY_M(M), .ADDR_WIDTH(AW), .DRAIN_LAT(DL), .TIMEOUT(TO)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
        .i_cfg_num_rows(i_cfg_num_rows), .i_cfg_num_cols(i_cfg_num_cols),
        .i_cfg_a_base(i_cfg_a_base), .i_cfg_w_base(i_cfg_w_base),
        .i_cfg_o_base(i_cfg_o_base), .i_cfg_chain(i_cfg_chain),
        .i_cfg_intra_o_base(i_cfg_intra_o_base), .i_cfg_intra_a_base(i_cfg_intra_a_base),
        .i_Intra_sig_end(i_Intra_sig_end),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_sa_reset(o_sa_reset),
        .o_a_buf_on(o_a_buf_on), .o_w_buf_on(o_w_buf_on), .o_mode(o_mode),
        .o_o_ag_o_on(o_o_ag_o_on), .o_Intranet_on(o_Intranet_on),
        .o_Intra_sig_start(o_Intra_sig_start),
        .o_operation_signal_in(o_operation_signal_in),
        .o_a_base_addr(o_a_base_addr), .o_w_base_addr(o_w_base_addr),
        .o_o_base_addr(o_o_base_addr), .o_Intra_O_base_addr(o_Intra_O_base_addr),
        .o_Intra_A_base_addr(o_Intra_A_base_addr),
        .o_a_num_rows(o_a_num_rows), .o_w_num_cols(o_w_num_cols)
    );

    logic [72:0] w_all;
    assign w_all = {o_busy, o_done, o_err, o_sa_reset, o_a_buf_on, o_w_buf_on,
                    o_mode, o_o_ag_o_on, o_Intranet_on, o_Intra_sig_start,
                    o_operation_signal_in, o_a_base_addr, o_w_base_addr,
                    o_o_base_addr, o_Intra_O_base_addr, o_Intra_A_base_addr,
                    o_a_num_rows, o_w_num_cols};

    // end_dly < 0: Intra_sig_end never comes; extra_at > 0: stray start in that cycle
    typedef struct {
        int rows; int cols; bit chain; int end_dly; bit noise; int extra_at;
    } vec_t;

    typedef struct {
        int lat; int busy; int w; int a; int o; int clr; int intra; int istart;
        bit err; int rows; int cols;
        int ab; int wb; int ob; int iob; int iab;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   m_err    = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        n_checks++;
        if (w_all != '0) begin
            n_fail++;
            $display("FAIL %s: outputs=%h expected all zero", name, w_all);
        end
    endtask

    // Expected opcode for cycle c after an accepted start (cycle 1 = CLR)
    function automatic logic [2:0] exp_op(input int c, input vec_t v);
        if (v.rows == 0 || v.cols == 0) return OP_IDLE;
        if (c >= 2 && c <= 1 + v.cols) return OP_LOADW;
        if (c > 1 + v.cols && c <= 1 + v.cols + v.rows) return OP_COMPUTE;
        if (c > 1 + v.cols + v.rows && c <= 1 + v.cols + v.rows + DL) return OP_DRAIN;
        return OP_IDLE;
    endfunction

    task automatic run_tile(input vec_t v, input string tag);
        exp_t e;
        bit   zero;
        int   intra_len;
        int   c, j, done_c;
        int   n_busy, n_w, n_mode, n_a, n_o, n_clr, n_intra, n_ist, n_phase_bad;
        int   n_hold_bad;
        bit   err_at_done;
        logic [2:0] op;

        zero = (v.rows == 0) || (v.cols == 0);
        intra_len = !v.chain ? 0 : (v.end_dly < 0 ? TO : v.end_dly + 1);
        e.lat    = zero ? 1 : 1 + v.cols + v.rows + DL + intra_len + 1;
        e.busy   = e.lat - 1;
        e.w      = zero ? 0 : v.cols;
        e.a      = zero ? 0 : v.rows;
        e.o      = zero ? 0 : DL;
        e.clr    = zero ? 0 : 1;
        e.intra  = zero ? 0 : intra_len;
        e.istart = (zero || !v.chain) ? 0 : 1;
        if (!zero) m_err = v.chain && (v.end_dly < 0);
        e.err    = m_err;
        e.rows   = v.rows;
        e.cols   = v.cols;
        e.ab     = int'($urandom_range(0, 1023));
        e.wb     = int'($urandom_range(0, 1023));
        e.ob     = int'($urandom_range(0, 1023));
        e.iob    = int'($urandom_range(0, 1023));
        e.iab    = int'($urandom_range(0, 1023));

        @(negedge clk);
        i_cfg_num_rows     = RW'(v.rows);
        i_cfg_num_cols     = CW'(v.cols);
        i_cfg_chain        = v.chain;
        i_cfg_a_base       = AW'(e.ab);
        i_cfg_w_base       = AW'(e.wb);
        i_cfg_o_base       = AW'(e.ob);
        i_cfg_intra_o_base = AW'(e.iob);
        i_cfg_intra_a_base = AW'(e.iab);
        i_Intra_sig_end    = v.noise;
        i_start            = 1'b1;
        sb.push_back(e);

        j = -1; done_c = 0; err_at_done = 1'b0;
        n_busy = 0; n_w = 0; n_mode = 0; n_a = 0; n_o = 0;
        n_clr = 0; n_intra = 0; n_ist = 0; n_phase_bad = 0;
        for (c = 1; c <= BUDGET; c++) begin
            @(negedge clk);
            op = exp_op(c, v);
            n_busy  += int'(o_busy);
            n_w     += int'(o_w_buf_on);
            n_mode  += int'(o_mode);
            n_a     += int'(o_a_buf_on);
            n_o     += int'(o_o_ag_o_on);
            n_clr   += int'(o_sa_reset);
            n_intra += int'(o_Intranet_on);
            n_ist   += int'(o_Intra_sig_start);
            if (o_operation_signal_in != op
                || o_w_buf_on != (op == OP_LOADW)
                || o_mode != (op == OP_LOADW)
                || o_a_buf_on != (op == OP_COMPUTE)
                || o_o_ag_o_on != (op == OP_DRAIN)
                || o_sa_reset != (c == 1 && !zero))
                n_phase_bad++;
            if (o_Intra_sig_start && j < 0) j = c;
            if (o_done) begin
                done_c = c;
                err_at_done = o_err;
                break;
            end
            i_start = (c == v.extra_at);
            i_Intra_sig_end = v.noise ||
                (v.chain && j >= 0 && v.end_dly >= 0 && c == j + v.end_dly);
        end
        i_start = 1'b0;
        i_Intra_sig_end = 1'b0;

        e = sb.pop_front();
        if (done_c == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_done_timeout: no done within %0d cycles", tag, BUDGET);
            return;
        end
        chk({tag, "_done_latency"}, done_c, e.lat);
        chk({tag, "_busy_cycles"}, n_busy, e.busy);
        chk({tag, "_w_buf_on_cycles"}, n_w, e.w);
        chk({tag, "_mode_cycles"}, n_mode, e.w);
        chk({tag, "_a_buf_on_cycles"}, n_a, e.a);
        chk({tag, "_o_ag_o_on_cycles"}, n_o, e.o);
        chk({tag, "_sa_reset_cycles"}, n_clr, e.clr);
        chk({tag, "_Intranet_on_cycles"}, n_intra, e.intra);
        chk({tag, "_Intra_sig_start_cycles"}, n_ist, e.istart);
        chk({tag, "_phase_pattern_errors"}, n_phase_bad, 0);
        chk({tag, "_err_at_done"}, int'(err_at_done), int'(e.err));

        // Scramble config without a start: latched outputs must hold
        @(negedge clk);
        i_cfg_num_rows     = RW'(v.rows + 1);
        i_cfg_num_cols     = CW'(v.cols + 2);
        i_cfg_a_base       = ~AW'(e.ab);
        i_cfg_w_base       = ~AW'(e.wb);
        i_cfg_o_base       = ~AW'(e.ob);
        i_cfg_intra_o_base = ~AW'(e.iob);
        i_cfg_intra_a_base = ~AW'(e.iab);
        n_hold_bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (o_busy || o_done || o_Intranet_on) n_hold_bad++;
        end
        chk({tag, "_idle_after_done_errors"}, n_hold_bad, 0);
        chk({tag, "_a_num_rows"}, int'(o_a_num_rows), e.rows);
        chk({tag, "_w_num_cols"}, int'(o_w_num_cols), e.cols);
        chk({tag, "_a_base_addr"}, int'(o_a_base_addr), e.ab);
        chk({tag, "_w_base_addr"}, int'(o_w_base_addr), e.wb);
        chk({tag, "_o_base_addr"}, int'(o_o_base_addr), e.ob);
        chk({tag, "_Intra_O_base_addr"}, int'(o_Intra_O_base_addr), e.iob);
        chk({tag, "_Intra_A_base_addr"}, int'(o_Intra_A_base_addr), e.iab);
    endtask

    initial begin
        int  k, n_done, n_busy;
        bit  seen;

        vecs.push_back('{16, 16, 1'b0, 0, 1'b0, 0});
        vecs.push_back('{3, 5, 1'b0, 0, 1'b1, 0});
        vecs.push_back('{4, 2, 1'b1, 7, 1'b0, 0});
        vecs.push_back('{0, 5, 1'b0, 0, 1'b0, 0});
        vecs.push_back('{5, 0, 1'b0, 0, 1'b0, 0});
        vecs.push_back('{1, 1, 1'b1, 0, 1'b0, 0});
        vecs.push_back('{3, 5, 1'b0, 0, 1'b0, 4});
        vecs.push_back('{2, 2, 1'b0, 0, 1'b0, 37});
        vecs.push_back('{16, 1, 1'b0, 0, 1'b0, 0});
`ifdef SEQ_INTRA_TIMEOUT_EN
        vecs.push_back('{2, 3, 1'b1, -1, 1'b0, 0});
        vecs.push_back('{0, 4, 1'b0, 0, 1'b0, 0});
        vecs.push_back('{2, 2, 1'b0, 0, 1'b0, 0});
`endif

        i_reset = 1'b0;
        i_start = 1'b0;
        i_cfg_num_rows = '1;
        i_cfg_num_cols = '1;
        i_cfg_a_base = '1;
        i_cfg_w_base = '1;
        i_cfg_o_base = '1;
        i_cfg_chain = 1'b1;
        i_cfg_intra_o_base = '1;
        i_cfg_intra_a_base = '1;
        i_Intra_sig_end = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_outputs");
        i_reset = 1'b1;
        m_err = 1'b0;

        foreach (vecs[i]) run_tile(vecs[i], $sformatf("vec%0d", i));

        // Reset pulled low in the middle of STREAM
        @(negedge clk);
        i_cfg_num_rows = RW'(8);
        i_cfg_num_cols = CW'(4);
        i_cfg_chain    = 1'b0;
        i_start        = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        seen = 1'b0;
        for (k = 0; k < 50; k++) begin
            if (o_a_buf_on) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("abort_reached_stream", int'(seen), 1);
        i_reset = 1'b0;
        @(negedge clk);
        chk_all_zero("abort_outputs");
        i_reset = 1'b1;
        m_err = 1'b0;
        n_done = 0;
        n_busy = 0;
        for (k = 0; k < 80; k++) begin
            @(negedge clk);
            n_done += int'(o_done);
            n_busy += int'(o_busy);
        end
        chk("abort_no_done", n_done, 0);
        chk("abort_no_busy", n_busy, 0);
        chk_all_zero("abort_idle_outputs");

        run_tile(vecs[0], "post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
